dphy_lane_delay_cal: RTL

Per-lane HS data delay calibration controller for the D-PHY receive lane.
- Sweeps the 5-bit IDELAY tap value that feeds the lane's delay input (`lane_delay`/`delay_act`) and scores every tap using SoT sync-byte hits and sync errors reported by the lane aligner.
- Selects the centre of the longest contiguous passing window and loads it into the lane.
- Sits in the `px_clk` domain beside each data lane and is started by the CSI-2 top-level control after clock lock.

---
 rtl/csi2_rx_pkg.sv | 23 ++
 rtl/dphy_cal_window_scorer.sv | 72 +++++++
 rtl/dphy_lane_delay_cal.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/csi2_rx_pkg.sv
// Shared CSI-2 receive definitions: D-PHY delay-line geometry and calibration state encodings.
package csi2_rx_pkg;

    localparam int DPHY_DELAY_TAPS = 32;
    localparam int DPHY_DELAY_W    = 5;

    typedef enum logic [2:0] {
        CAL_IDLE,
        CAL_LOAD,
        CAL_SETTLE,
        CAL_MEASURE,
        CAL_EVAL,
        CAL_APPLY,
        CAL_DONE
    } dphy_cal_state_t;

    typedef enum logic [1:0] {
        SCORE_IDLE,
        SCORE_SETTLE,
        SCORE_MEASURE
    } dphy_score_phase_t;

endpackage

// File: rtl/dphy_cal_window_scorer.sv
// Per-tap scoring: waits out the settle time, then counts sync hits and latches any sync error
// over a fixed measurement window.
module dphy_cal_window_scorer
    import csi2_rx_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 4096,
    parameter int MIN_SYNC      = 4,
    parameter int CNT_W         = 16
) (
    input  logic px_clk,
    input  logic rst,
    input  logic arm,
    input  logic sync_hit,
    input  logic sync_err,
    output logic settle_done,
    output logic window_done,
    output logic pass
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIT_MIN     = CNT_W'(MIN_SYNC);
    localparam logic [CNT_W-1:0] HIT_SAT     = {CNT_W{1'b1}};

    dphy_score_phase_t phase;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  hit_cnt;
    logic              err_flag;

    assign settle_done = (phase == SCORE_SETTLE)  && (cnt == SETTLE_LAST);
    assign window_done = (phase == SCORE_MEASURE) && (cnt == WINDOW_LAST);
    assign pass        = (hit_cnt >= HIT_MIN) && !err_flag;

    // Pulses seen outside MEASURE never reach the hit counter or error flag.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            phase    <= SCORE_IDLE;
            cnt      <= '0;
            hit_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (arm) begin
            phase    <= SCORE_SETTLE;
            cnt      <= '0;
            hit_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            case (phase)
                SCORE_SETTLE: begin
                    if (settle_done) begin
                        phase <= SCORE_MEASURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCORE_MEASURE: begin
                    if (sync_hit && (hit_cnt != HIT_SAT))
                        hit_cnt <= hit_cnt + 1'b1;
                    if (sync_err)
                        err_flag <= 1'b1;
                    if (window_done)
                        phase <= SCORE_IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dphy_lane_delay_cal.sv
// D-PHY HS lane delay calibration: sweeps all IDELAY taps, keeps the longest passing run and loads
// its centre. Optional DPHY_CAL_EYE_MAP_EN adds a per-tap pass map output for debug readout.
module dphy_lane_delay_cal
    import csi2_rx_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 4096,
    parameter int MIN_SYNC      = 4,
    parameter int CNT_W         = 16
) (
    input  logic                    px_clk_i,
    input  logic                    rst_i,
    input  logic                    cal_start_i,
    input  logic                    sync_hit_i,
    input  logic                    sync_err_i,
    output logic                    delay_act_o,
    output logic [DPHY_DELAY_W-1:0] lane_delay_o,
    output logic                    cal_busy_o,
    output logic                    cal_done_o,
    output logic                    cal_fail_o,
    output logic [DPHY_DELAY_W-1:0] cal_tap_o
`ifdef DPHY_CAL_EYE_MAP_EN
    ,
    output logic [DPHY_DELAY_TAPS-1:0] eye_map_o
`endif
);

    localparam int RUN_W = DPHY_DELAY_W + 1;
    localparam logic [DPHY_DELAY_W-1:0] LAST_TAP = DPHY_DELAY_W'(DPHY_DELAY_TAPS - 1);

    dphy_cal_state_t         state;
    logic [DPHY_DELAY_W-1:0] tap;
    logic [RUN_W-1:0]        run_len, best_len;
    logic [DPHY_DELAY_W-1:0] run_start, best_start;

    logic                    settle_done, window_done, pass;
    logic [RUN_W-1:0]        run_len_nxt, best_len_nxt;
    logic [DPHY_DELAY_W-1:0] run_start_nxt, best_start_nxt, centre_nxt;

    dphy_cal_window_scorer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .MIN_SYNC      (MIN_SYNC),
        .CNT_W         (CNT_W)
    ) u_scorer (
        .px_clk      (px_clk_i),
        .rst         (rst_i),
        .arm         (state == CAL_LOAD),
        .sync_hit    (sync_hit_i),
        .sync_err    (sync_err_i),
        .settle_done (settle_done),
        .window_done (window_done),
        .pass        (pass)
    );

    // Run/best update for the current EVAL; the centre comes from the post-update best so the
    // final load strobe can be registered on the EVAL->APPLY edge.
    always_comb begin
        run_len_nxt    = pass ? run_len + 1'b1 : '0;
        run_start_nxt  = (pass && (run_len == '0)) ? tap : run_start;
        best_len_nxt   = best_len;
        best_start_nxt = best_start;
        if (run_len_nxt > best_len) begin
            best_len_nxt   = run_len_nxt;
            best_start_nxt = run_start_nxt;
        end
        centre_nxt = best_start_nxt + DPHY_DELAY_W'((best_len_nxt - 1'b1) >> 1);
    end

    always_ff @(posedge px_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= CAL_IDLE;
            tap          <= '0;
            run_len      <= '0;
            run_start    <= '0;
            best_len     <= '0;
            best_start   <= '0;
            delay_act_o  <= 1'b0;
            lane_delay_o <= '0;
            cal_busy_o   <= 1'b0;
            cal_done_o   <= 1'b0;
            cal_fail_o   <= 1'b0;
            cal_tap_o    <= '0;
`ifdef DPHY_CAL_EYE_MAP_EN
            eye_map_o    <= '0;
`endif
        end else begin
            delay_act_o <= 1'b0;
            case (state)
                CAL_IDLE, CAL_DONE: begin
                    if (cal_start_i) begin
                        state        <= CAL_LOAD;
                        tap          <= '0;
                        run_len      <= '0;
                        run_start    <= '0;
                        best_len     <= '0;
                        best_start   <= '0;
                        delay_act_o  <= 1'b1;
                        lane_delay_o <= '0;
                        cal_busy_o   <= 1'b1;
                        cal_done_o   <= 1'b0;
                        cal_fail_o   <= 1'b0;
                        cal_tap_o    <= '0;
`ifdef DPHY_CAL_EYE_MAP_EN
                        eye_map_o    <= '0;
`endif
                    end
                end
                CAL_LOAD:    state <= CAL_SETTLE;
                CAL_SETTLE:  if (settle_done) state <= CAL_MEASURE;
                CAL_MEASURE: if (window_done) state <= CAL_EVAL;
                CAL_EVAL: begin
                    run_len     <= run_len_nxt;
                    run_start   <= run_start_nxt;
                    best_len    <= best_len_nxt;
                    best_start  <= best_start_nxt;
                    delay_act_o <= 1'b1;
`ifdef DPHY_CAL_EYE_MAP_EN
                    eye_map_o[tap] <= pass;
`endif
                    if (tap == LAST_TAP) begin
                        state        <= CAL_APPLY;
                        lane_delay_o <= (best_len_nxt == '0) ? '0 : centre_nxt;
                    end else begin
                        state        <= CAL_LOAD;
                        tap          <= tap + 1'b1;
                        lane_delay_o <= tap + 1'b1;
                    end
                end
                CAL_APPLY: begin
                    state      <= CAL_DONE;
                    cal_busy_o <= 1'b0;
                    cal_done_o <= 1'b1;
                    cal_fail_o <= (best_len == '0);
                    cal_tap_o  <= lane_delay_o;
                end
                default: state <= CAL_IDLE;
            endcase
        end
    end

endmodule
